// File: rtl/modmul_stream_shell.sv
// -----------------------------------------------------------------------------
// modmul_stream_shell
//   Streaming wrapper around the multi-limb modmul core. Operands A/B arrive one
//   limb per beat (element 0 first) over a valid/ready port. They are held stable
//   for the core for MUL_LAT+1 cycles, and the result C is captured. C is then
//   streamed out one limb per beat with backpressure. Input and output phases
//   never overlap.
//
//   Optional feature macro: MODMUL_FEEDBACK_EN
//     When defined, the reuse_a port exists. It is sampled on the first input
//     beat. If it is 1, operand A is taken from the last captured C for the
//     whole operation (din1 is ignored). This gives ladder steps without an
//     external readback.
//
//   Ports
//     clk        clock, all state on rising edge
//     rst        asynchronous active-low reset
//     in_valid   din1/din2 limb valid
//     in_ready   shell accepts a limb this cycle
//     din1/din2  A / B limb
//     out_valid  dout limb valid
//     out_ready  downstream accepts dout
//     dout       C limb
//     out_last   marks limb NUM_ELEMENTS-1 of C
//     busy       high while computing or unloading
//     reuse_a    (MODMUL_FEEDBACK_EN only) load A from last result
// -----------------------------------------------------------------------------

// Combinational modular multiplier: C = A*B mod M. The fixed modulus is
// M = 2^(WORD_LEN*NUM_ELEMENTS) - (REDUCT_SEGMENT*NONREDUCT_SEGMENT + 1).
module modmul_core #(
  parameter int NUM_ELEMENTS      = 17,
  parameter int BIT_LEN           = 17,
  parameter int WORD_LEN          = 16,
  parameter int REDUCT_SEGMENT    = 19,
  parameter int NONREDUCT_SEGMENT = 16
) (
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] i_a,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] i_b,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] o_c
);
  localparam int OP_W = NUM_ELEMENTS * BIT_LEN;
  localparam int PW   = 2 * OP_W;
  localparam logic [PW-1:0] MODULUS =
    (PW'(1) << (WORD_LEN * NUM_ELEMENTS)) - PW'(REDUCT_SEGMENT * NONREDUCT_SEGMENT + 1);

  logic [PW-1:0] w_prod;

  assign w_prod = PW'(i_a) * PW'(i_b);
  assign o_c    = OP_W'(w_prod % MODULUS);
endmodule

// state     | meaning
// S_LOAD    | accepting A/B limbs, in_ready=1
// S_COMPUTE | operands frozen, waiting MUL_LAT+1 cycles for the core
// S_UNLOAD  | streaming C limbs out under backpressure
module modmul_stream_shell #(
  parameter int NUM_ELEMENTS      = 17,
  parameter int BIT_LEN           = 17,
  parameter int WORD_LEN          = 16,
  parameter int REDUCT_SEGMENT    = 19,
  parameter int NONREDUCT_SEGMENT = 16,
  parameter int MUL_LAT           = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] din1,
  input  logic [BIT_LEN-1:0] din2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] dout,
  output logic               out_last,
  output logic               busy
`ifdef MODMUL_FEEDBACK_EN
  ,
  input  logic               reuse_a
`endif
);
  localparam int OP_W  = NUM_ELEMENTS * BIT_LEN;
  localparam int CNT_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int LAT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LAT_W-1:0]   r_lat;
  logic [BIT_LEN-1:0] r_a [NUM_ELEMENTS];
  logic [BIT_LEN-1:0] r_b [NUM_ELEMENTS];
  logic [BIT_LEN-1:0] r_c [NUM_ELEMENTS];

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OP_W-1:0]    w_a_flat;
  logic [OP_W-1:0]    w_b_flat;
  logic [OP_W-1:0]    w_c_core;
  logic [OP_W-1:0]    w_c_cap;
  logic               w_in_fire;
  logic               w_use_fb;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_in_fire = in_valid & in_ready;

`ifdef MODMUL_FEEDBACK_EN
  logic r_reuse;
  // reuse_a is only meaningful on the first beat; later beats follow the latch.
  assign w_use_fb = (r_cnt == '0) ? reuse_a : r_reuse;
`else
  assign w_use_fb = 1'b0;
`endif

  always_comb begin
    w_a_flat = '0;
    w_b_flat = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      w_a_flat[k*BIT_LEN +: BIT_LEN] = r_a[k];
      w_b_flat[k*BIT_LEN +: BIT_LEN] = r_b[k];
    end
  end

  modmul_core #(
    .NUM_ELEMENTS      (NUM_ELEMENTS),
    .BIT_LEN           (BIT_LEN),
    .WORD_LEN          (WORD_LEN),
    .REDUCT_SEGMENT    (REDUCT_SEGMENT),
    .NONREDUCT_SEGMENT (NONREDUCT_SEGMENT)
  ) u_core (
    .i_a (w_a_flat),
    .i_b (w_b_flat),
    .o_c (w_c_core)
  );

  // Core pipeline depth. The operands are frozen for the whole COMPUTE phase,
  // so the stage registers need no valid tracking.
  if (MUL_LAT == 0) begin : g_comb
    assign w_c_cap = w_c_core;
  end else begin : g_pipe
    logic [OP_W-1:0] r_pipe [MUL_LAT];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_c_core;
        for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_c_cap = r_pipe[MUL_LAT-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_lat     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      dout      <= '0;
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= '0;
      end
`ifdef MODMUL_FEEDBACK_EN
      r_reuse   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_a[r_cnt] <= w_use_fb ? r_c[r_cnt] : din1;
            r_b[r_cnt] <= din2;
`ifdef MODMUL_FEEDBACK_EN
            if (r_cnt == '0) r_reuse <= reuse_a;
`endif
            if (r_cnt == CNT_LAST) begin
              r_state  <= S_COMPUTE;
              r_cnt    <= '0;
              r_lat    <= LAT_W'(MUL_LAT);
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end else begin
            // First edge after reset release raises in_ready.
            in_ready <= 1'b1;
          end
        end

        S_COMPUTE: begin
          if (r_lat == '0) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) r_c[k] <= w_c_cap[k*BIT_LEN +: BIT_LEN];
            dout      <= w_c_cap[BIT_LEN-1:0];
            out_last  <= (CNT_LAST == '0);
            out_valid <= 1'b1;
            r_state   <= S_UNLOAD;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end

        S_UNLOAD: begin
          if (out_ready) begin
            if (r_cnt == CNT_LAST) begin
              r_state   <= S_LOAD;
              r_cnt     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              r_cnt    <= w_cnt_nxt;
              dout     <= r_c[w_cnt_nxt];
              out_last <= (w_cnt_nxt == CNT_LAST);
            end
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_modmul_stream_shell.sv
module tb_modmul_stream_shell;
  localparam int N       = 17;
  localparam int BL      = 17;
  localparam int MUL_LAT = 3;
  localparam int OPW     = N * BL;
  localparam int PW      = 2 * OPW;
  localparam int LAT_EXP = MUL_LAT + 2;
  // Core modulus: 2^272 - 305
  localparam logic [OPW-1:0] MOD = (OPW'(1) << 272) - OPW'(305);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BL-1:0] din1 = '0;
  logic [BL-1:0] din2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BL-1:0] dout;
  logic          out_last;
  logic          busy;
`ifdef MODMUL_FEEDBACK_EN
  logic          reuse_a = 1'b0;
`endif

  modmul_stream_shell #(
    .NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(16),
    .REDUCT_SEGMENT(19), .NONREDUCT_SEGMENT(16), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_last(out_last), .busy(busy)
`ifdef MODMUL_FEEDBACK_EN
    , .reuse_a(reuse_a)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: plain modular product on wide integers.
  function automatic logic [OPW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    p = p % PW'(MOD);
    return p[OPW-1:0];
  endfunction

  function automatic logic [OPW-1:0] rand_mod();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    t = t % 320'(MOD);
    return t[OPW-1:0];
  endfunction

  // Scoreboard entries: {last, limb}
  logic [BL:0] exp_q[$];
  logic [OPW-1:0] last_c = '0;
  int  last_in_cyc = 0;
  bit  lat_armed = 1'b0;
  int  bp_mode = 0;

  task automatic expect_op(input logic [OPW-1:0] c);
    for (int k = 0; k < N; k++) exp_q.push_back({(k == N-1), c[k*BL +: BL]});
    last_c = c;
  endtask

  task automatic send_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input bit gaps, input bit fb, input int nbeats);
    int k = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (k < nbeats && guard < 2000) begin
      @(negedge clk);
      guard++;
      tog = ~tog;
      in_valid = gaps ? tog : 1'b1;
      din1 = fb ? 17'h1FFFF : a[k*BL +: BL];
      din2 = b[k*BL +: BL];
`ifdef MODMUL_FEEDBACK_EN
      reuse_a = fb && (k == 0);
`endif
      if (in_valid && in_ready) begin
        if (k == N-1) begin
          last_in_cyc = cyc;
          lat_armed   = 1'b1;
        end
        k++;
      end
    end
    if (k < nbeats) chk(1'b0, "input_timeout", 64'(k), 64'(nbeats));
    if (nbeats == N) begin
      // Junk presented while computing must be ignored.
      repeat (MUL_LAT + 1) begin
        @(negedge clk);
        in_valid = 1'b1;
        din1 = BL'($urandom);
        din2 = BL'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
`ifdef MODMUL_FEEDBACK_EN
    reuse_a = 1'b0;
`endif
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: drives out_ready and checks every accepted output beat.
  int          mbeat = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [BL-1:0] prev_dout = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    logic [BL:0] e;
    bit rdy;
    if (!rst) begin
      out_ready  = 1'b0;
      prev_stall = 1'b0;
      mbeat      = 0;
      stall_cnt  = 0;
    end else begin
      rdy = 1'b1;
      if (bp_mode == 1) begin
        if (out_valid && mbeat == 3 && stall_cnt < 5) begin
          rdy = 1'b0;
          stall_cnt++;
        end
      end else if (bp_mode == 2) begin
        rdy = ($urandom_range(0, 1) == 1);
      end
      out_ready = rdy;

      if (out_valid) chk(!in_ready, "phase_overlap", 64'(in_ready), 64'd0);
      if (out_valid) chk(busy, "busy_unload", 64'(busy), 64'd1);
      if (in_ready)  chk(!busy, "busy_load", 64'(busy), 64'd0);
      if (prev_stall) begin
        chk(out_valid, "hold_valid", 64'(out_valid), 64'd1);
        chk(dout == prev_dout, "hold_dout", 64'(dout), 64'(prev_dout));
        chk(out_last == prev_last, "hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && lat_armed) begin
        chk((cyc - last_in_cyc) == LAT_EXP, "latency", 64'(cyc - last_in_cyc), 64'(LAT_EXP));
        lat_armed = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", 64'(dout), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk(dout == e[BL-1:0], $sformatf("dout_beat%0d", mbeat), 64'(dout), 64'(e[BL-1:0]));
          chk(out_last == e[BL], $sformatf("last_beat%0d", mbeat), 64'(out_last), 64'(e[BL]));
          if (e[BL]) begin
            mbeat = 0;
            stall_cnt = 0;
          end else begin
            mbeat++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_last  = out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OPW-1:0] a, b, c1;

    // Reset held with in_valid asserted.
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(dout == '0, "rst_dout", 64'(dout), 64'd0);
    chk(out_last == 1'b0, "rst_out_last", 64'(out_last), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b1, "in_ready_after_rst", 64'(in_ready), 64'd1);

    // Zero operand A, B = 0x12345 in every limb.
    bp_mode = 0;
    a = '0;
    for (int k = 0; k < N; k++) b[k*BL +: BL] = 17'h12345;
    expect_op(ref_mul(a, b));
    send_op(a, b, 1'b0, 1'b0, N);
    wait_drain();

    // Random golden operations, alternating free-flowing and random backpressure.
    for (int i = 0; i < 4; i++) begin
      bp_mode = (i % 2 == 1) ? 2 : 0;
      a = rand_mod();
      b = rand_mod();
      expect_op(ref_mul(a, b));
      send_op(a, b, (i == 3), 1'b0, N);
      wait_drain();
    end

    // Backpressure stall at beat 3 with gapped input.
    bp_mode = 1;
    a = rand_mod();
    b = rand_mod();
    expect_op(ref_mul(a, b));
    send_op(a, b, 1'b1, 1'b0, N);
    wait_drain();
    bp_mode = 0;

`ifdef MODMUL_FEEDBACK_EN
    // Feedback: op2 reuses C1 as A.
    a = rand_mod();
    b = rand_mod();
    c1 = ref_mul(a, b);
    expect_op(c1);
    send_op(a, b, 1'b0, 1'b0, N);
    wait_drain();
    b = rand_mod();
    expect_op(ref_mul(c1, b));
    send_op(a, b, 1'b0, 1'b1, N);
    wait_drain();
`else
    c1 = '0;
`endif

    // Reset after 8 input beats: no output, next op correct.
    a = rand_mod();
    b = rand_mod();
    send_op(a, b, 1'b0, 1'b0, 8);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
    chk(in_ready == 1'b0, "midrst_in_ready", 64'(in_ready), 64'd0);
    chk(busy == 1'b0, "midrst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    last_c = '0;
    repeat (3) @(negedge clk);
    chk(out_valid == 1'b0, "midrst_no_output", 64'(out_valid), 64'd0);
    a = rand_mod() ^ c1;
    a = a % MOD;
    b = rand_mod();
    expect_op(ref_mul(a, b));
    send_op(a, b, 1'b0, 1'b0, N);
    wait_drain();

    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
